board_reader: RTL and testbench
===============================

BOARD_READER -- requirements
Module: board_reader

Interface
REQ-001 SHALL have parameter SCAN_DOWN, default 0, scan order: 0 = row 0 first up to row 7; 1 = row 7 first down to row 0.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a snapshot and readout of the board.
REQ-005 SHALL have port cells  input  64  board contents; row k = cells[8k+7:8k].
REQ-006 SHALL have port row_ready  input  1  downstream accepts the current row.
REQ-007 SHALL have port row_valid  output  1  row_sel/row_val hold a valid row.
REQ-008 SHALL have port row_sel  output  3  index of the row presented.
REQ-009 SHALL have port row_val  output  8  contents of the row presented.
REQ-010 SHALL have port busy  output  1  a readout is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at the end of a readout.
REQ-012 SHALL have port pop_count  output  7  number of set cells in the last completed readout, range 0..64.

Function
REQ-013 SHALL implement a state machine with the states IDLE, SEND and DONE.
REQ-014 In IDLE with start=1: the block SHALL capture cells into an internal 64-bit snapshot, clear the pop accumulator, set the row index to 0 (SCAN_DOWN=0) or 7 (SCAN_DOWN=1), and enter SEND on the next edge.
REQ-015 Latency: row_valid SHALL first assert in the cycle after start is sampled high in IDLE.
REQ-016 In SEND: row_valid=1, row_sel=index, and row_val SHALL equal snapshot[8*index+7:8*index].
REQ-017 A transfer SHALL occur in any SEND cycle with row_valid=1 and row_ready=1; at most one row transfers per cycle.
REQ-018 While row_valid=1 and row_ready=0, row_sel and row_val SHALL hold stable.
REQ-019 On each transfer, the popcount of row_val SHALL be added to the accumulator; the width is 7 bits and the sum never exceeds 64.
REQ-020 On a transfer of a non-final row: the index SHALL step by +1 (SCAN_DOWN=0) or -1 (SCAN_DOWN=1), and the next row SHALL be presented in the following cycle with no bubble.
REQ-021 On the transfer of the final row (row 7 for SCAN_DOWN=0, row 0 for SCAN_DOWN=1): the block SHALL enter DONE; the index SHALL NOT wrap.
REQ-022 In DONE: done=1 and row_valid=0 for exactly one cycle; pop_count SHALL present the final sum; the next state SHALL be IDLE.
REQ-023 pop_count SHALL update only on entry to DONE and SHALL hold until the next DONE; it SHALL NOT be cleared by start.
REQ-024 busy SHALL be 1 in SEND and DONE, and 0 in IDLE.
REQ-025 start SHALL be ignored in SEND and DONE, including a start pulse in the DONE cycle; a new readout requires start in IDLE.
REQ-026 Changes on cells after the capture cycle SHALL NOT affect the rows output during that readout.
REQ-027 row_ready sampled while row_valid=0 SHALL have no effect.
REQ-028 A readout with row_ready held at 1 SHALL take 10 cycles from the start edge through the done pulse: 1 capture cycle, 8 SEND cycles, 1 DONE cycle.

Reset
REQ-029 With reset=1 at a clock edge: state SHALL become IDLE, and row_valid, row_sel, row_val, busy, done, pop_count, the snapshot, the index and the accumulator SHALL all become 0.
REQ-030 reset SHALL take priority over start and row_ready.
REQ-031 Reset during SEND or DONE SHALL abort the readout; no done pulse SHALL follow, and pop_count SHALL read 0.

Verification
REQ-032 Full readout: cells=64'h8040201008040201, SCAN_DOWN=0, row_ready=1, start pulse -> rows 0..7 each with row_val=8'h01,02,04,..,80 on consecutive cycles; done pulse at cycle 10; pop_count=8.
REQ-033 Backpressure: cells=all ones, row_ready toggled 1,0,0,1,... -> row_val=8'hFF held stable during stalls; exactly 8 transfers; pop_count=64.
REQ-034 Snapshot isolation: start with cells=0, then cells=all ones from the next cycle onward -> all 8 rows show 8'h00; pop_count=0.
REQ-035 Reverse scan: SCAN_DOWN=1, cells=64'h0000_0000_0000_00FF -> row_sel sequence 7..0; row 0 shows 8'hFF; pop_count=8.
REQ-036 Ignored start and reset abort: start pulses during SEND cause no restart. In a separate run, reset asserted on the 4th row -> row_valid=0 and busy=0 the next cycle, no done pulse, pop_count=0; a start in IDLE afterwards runs a normal readout.

Source files
------------

// File: rtl/board_reader.sv
// board_reader: snapshots a 64-cell board and streams it out one 8-bit row at a
// time over a valid/ready handshake, counting the set cells as the rows go out.
//
// Parameter
//   SCAN_DOWN  0: rows go out 0..7, 1: rows go out 7..0
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high; aborts any readout in progress
//   start      request a snapshot and readout (only honoured while idle)
//   cells      board contents, row k = cells[8k+7:8k]
//   row_ready  downstream accepts the presented row
//   row_valid  row_sel/row_val hold a valid row
//   row_sel    index of the presented row
//   row_val    contents of the presented row
//   busy       a readout is in progress (SEND or DONE)
//   done       one-cycle pulse closing a readout
//   pop_count  number of set cells in the last completed readout (0..64)
module board_reader #(
    parameter int unsigned SCAN_DOWN = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] cells,
    input  logic        row_ready,
    output logic        row_valid,
    output logic [2:0]  row_sel,
    output logic [7:0]  row_val,
    output logic        busy,
    output logic        done,
    output logic [6:0]  pop_count
);

    localparam logic [2:0] FirstRow = (SCAN_DOWN != 0) ? 3'd7 : 3'd0;
    localparam logic [2:0] LastRow  = (SCAN_DOWN != 0) ? 3'd0 : 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_e;

    state_e      state_q;
    logic [63:0] snap_q;
    logic [2:0]  idx_q;
    logic [6:0]  acc_q;
    logic        row_valid_q;
    logic [7:0]  row_val_q;
    logic        busy_q;
    logic        done_q;
    logic [6:0]  pop_count_q;

    logic [2:0]  idx_next;
    logic        last_row;
    logic [3:0]  row_ones;
    logic [6:0]  acc_sum;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] row_of(input logic [63:0] board, input logic [2:0] idx);
        return board[{idx, 3'b000} +: 8];
    endfunction

    always_comb begin
        idx_next = (SCAN_DOWN != 0) ? idx_q - 3'd1 : idx_q + 3'd1;
        last_row = (idx_q == LastRow);
        row_ones = popcount8(row_val_q);
        // At most 64 ones over a readout, so 7 bits never overflow.
        acc_sum  = acc_q + {3'd0, row_ones};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            snap_q      <= 64'd0;
            idx_q       <= 3'd0;
            acc_q       <= 7'd0;
            row_valid_q <= 1'b0;
            row_val_q   <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pop_count_q <= 7'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        snap_q      <= cells;
                        acc_q       <= 7'd0;
                        idx_q       <= FirstRow;
                        // First row is taken from the live input, which is exactly
                        // what lands in the snapshot on this edge.
                        row_val_q   <= row_of(cells, FirstRow);
                        row_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StSend;
                    end
                end
                StSend: begin
                    // row_valid is always high here, so ready alone means transfer.
                    if (row_ready) begin
                        acc_q <= acc_sum;
                        if (last_row) begin
                            // Index stays on the final row rather than wrapping.
                            row_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            pop_count_q <= acc_sum;
                            state_q     <= StDone;
                        end else begin
                            idx_q     <= idx_next;
                            row_val_q <= row_of(snap_q, idx_next);
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign row_valid = row_valid_q;
    assign row_sel   = idx_q;
    assign row_val   = row_val_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pop_count = pop_count_q;

endmodule

// File: tb/tb_board_reader.sv
module tb_board_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0;
    logic        start1;
    logic [63:0] cells;
    logic        row_ready;

    logic        row_valid0, row_valid1;
    logic [2:0]  row_sel0, row_sel1;
    logic [7:0]  row_val0, row_val1;
    logic        busy0, busy1;
    logic        done0, done1;
    logic [6:0]  pop_count0, pop_count1;

    always #5 clk = ~clk;

    board_reader #(.SCAN_DOWN(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start0),
        .cells     (cells),
        .row_ready (row_ready),
        .row_valid (row_valid0),
        .row_sel   (row_sel0),
        .row_val   (row_val0),
        .busy      (busy0),
        .done      (done0),
        .pop_count (pop_count0)
    );

    board_reader #(.SCAN_DOWN(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .cells     (cells),
        .row_ready (row_ready),
        .row_valid (row_valid1),
        .row_sel   (row_sel1),
        .row_val   (row_val1),
        .busy      (busy1),
        .done      (done1),
        .pop_count (pop_count1)
    );

    int total = 0;
    int bad = 0;

    // Scoreboard queues: expected {row_sel,row_val} per transfer, pop_count per done.
    logic [10:0] exp_row0[$];
    logic [10:0] exp_row1[$];
    logic [6:0]  exp_pop0[$];
    logic [6:0]  exp_pop1[$];

    int ready_mode = 0;
    int rcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // row_ready driver: mode 0 always ready, mode 1 pattern 1,0,0 repeating.
    initial begin
        row_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            row_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
        end
    end

    // Monitor for the upward-scanning instance.
    initial begin
        logic        stall;
        logic [10:0] prev;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) check("hold0", {row_valid0, row_sel0, row_val0}, {1'b1, prev});
                if (row_valid0 && row_ready) begin
                    if (exp_row0.size() == 0) fail_now("row0_unexpected");
                    else check("row0", {row_sel0, row_val0}, exp_row0.pop_front());
                end
                stall = row_valid0 && !row_ready;
                prev  = {row_sel0, row_val0};
                if (done0) begin
                    check("done0_valid", row_valid0, 0);
                    check("done0_busy", busy0, 1);
                    if (exp_pop0.size() == 0) fail_now("done0_unexpected");
                    else check("pop0", pop_count0, exp_pop0.pop_front());
                end
            end
        end
    end

    // Monitor for the downward-scanning instance.
    initial begin
        logic        stall;
        logic [10:0] prev;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) check("hold1", {row_valid1, row_sel1, row_val1}, {1'b1, prev});
                if (row_valid1 && row_ready) begin
                    if (exp_row1.size() == 0) fail_now("row1_unexpected");
                    else check("row1", {row_sel1, row_val1}, exp_row1.pop_front());
                end
                stall = row_valid1 && !row_ready;
                prev  = {row_sel1, row_val1};
                if (done1) begin
                    check("done1_valid", row_valid1, 0);
                    if (exp_pop1.size() == 0) fail_now("done1_unexpected");
                    else check("pop1", pop_count1, exp_pop1.pop_front());
                end
            end
        end
    end

    // Returns at 1 ns after the edge that samples start.
    task automatic pulse_start(input int which);
        @(posedge clk);
        #1;
        if (which == 0) start0 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Counts falling edges after the start edge until done; n = 9 for an unstalled run.
    task automatic wait_done(input int which, output int n);
        logic v, b, d;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            v = (which == 0) ? row_valid0 : row_valid1;
            b = (which == 0) ? busy0 : busy1;
            d = (which == 0) ? done0 : done1;
            if (n == 1) begin
                check("first_valid", v, 1);
                check("first_busy", b, 1);
            end
            if (d) break;
            if (n >= 200) begin
                fail_now("done_timeout");
                break;
            end
        end
    endtask

    initial begin
        int n;
        logic [63:0] pat;
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        cells  = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_outs0", {row_valid0, row_sel0, row_val0, busy0, done0, pop_count0}, 0);
        check("rst_outs1", {row_valid1, row_sel1, row_val1, busy1, done1, pop_count1}, 0);

        // Full readout, one-hot diagonal, row_ready held high.
        cells = 64'h8040201008040201;
        for (int i = 0; i < 8; i++) exp_row0.push_back({3'(i), 8'h01 << i});
        exp_pop0.push_back(7'd8);
        pulse_start(0);
        wait_done(0, n);
        check("latency_full", n, 9);
        @(negedge clk);
        check("idle_busy0", busy0, 0);
        check("pop_hold0", pop_count0, 8);

        // Backpressure with all cells set; pop_count must not clear on start.
        cells = '1;
        ready_mode = 1;
        for (int i = 0; i < 8; i++) exp_row0.push_back({3'(i), 8'hFF});
        exp_pop0.push_back(7'd64);
        pulse_start(0);
        @(negedge clk);
        check("pop_kept_on_start", pop_count0, 8);
        wait_done(0, n);
        ready_mode = 0;

        // Snapshot isolation: cells change right after the capture edge.
        cells = 64'd0;
        for (int i = 0; i < 8; i++) exp_row0.push_back({3'(i), 8'h00});
        exp_pop0.push_back(7'd0);
        @(posedge clk);
        #1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        cells  = '1;
        wait_done(0, n);
        check("latency_snap", n, 9);

        // Reverse scan on the SCAN_DOWN=1 instance.
        cells = 64'h0000_0000_0000_00FF;
        for (int i = 7; i >= 1; i--) exp_row1.push_back({3'(i), 8'h00});
        exp_row1.push_back({3'd0, 8'hFF});
        exp_pop1.push_back(7'd8);
        pulse_start(1);
        wait_done(1, n);
        check("latency_rev", n, 9);

        // start held high through SEND and the DONE cycle must not restart.
        pat = 64'h0F0F_3355_00FF_1234;
        cells = pat;
        for (int i = 0; i < 8; i++) exp_row0.push_back({3'(i), pat[i*8 +: 8]});
        exp_pop0.push_back(7'd29);
        pulse_start(0);
        start0 = 1'b1;
        wait_done(0, n);
        check("latency_ign", n, 9);
        @(posedge clk);
        #1;
        start0 = 1'b0;
        @(negedge clk);
        check("no_restart", {busy0, row_valid0, done0}, 0);

        // Reset abort while the 4th row is presented.
        cells = '1;
        for (int i = 0; i < 8; i++) exp_row0.push_back({3'(i), 8'hFF});
        pulse_start(0);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (row_valid0 && row_sel0 == 3'd3) break;
            if (n >= 50) begin
                fail_now("row3_timeout");
                break;
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_row0.delete();
        @(negedge clk);
        check("abort_valid", row_valid0, 0);
        check("abort_busy", busy0, 0);
        check("abort_pop", pop_count0, 0);
        repeat (12) begin
            @(negedge clk);
            check("abort_no_done", done0, 0);
        end

        // Normal readout after the abort.
        cells = 64'h0102_0408_1020_4080;
        for (int i = 0; i < 8; i++) exp_row0.push_back({3'(i), 8'h80 >> i});
        exp_pop0.push_back(7'd8);
        pulse_start(0);
        wait_done(0, n);
        check("latency_after_abort", n, 9);

        repeat (3) @(negedge clk);
        check("left_rows0", exp_row0.size(), 0);
        check("left_rows1", exp_row1.size(), 0);
        check("left_pop0", exp_pop0.size(), 0);
        check("left_pop1", exp_pop1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
